microprogram_sequencer: RTL



---
 rtl/am2900_pkg.sv | 32 +++
 rtl/microprogram_sequencer_if.sv | 34 +++
 rtl/microprogram_sequencer_stack.sv | 79 +++++++
 rtl/microprogram_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/am2900_pkg.sv
// -----------------------------------------------------------------------------
// am2900_pkg
// Shared definitions for the microprogram sequencer:
//   - 4-bit opcode constants OP_JZ .. OP_TWB for the instruction input I
//   - cond_pass(): the branch-condition qualifier (PASS) used by decode
// -----------------------------------------------------------------------------
package am2900_pkg;

   localparam logic [3:0] OP_JZ   = 4'd0;
   localparam logic [3:0] OP_CJS  = 4'd1;
   localparam logic [3:0] OP_JMAP = 4'd2;
   localparam logic [3:0] OP_CJP  = 4'd3;
   localparam logic [3:0] OP_PUSH = 4'd4;
   localparam logic [3:0] OP_JSRP = 4'd5;
   localparam logic [3:0] OP_CJV  = 4'd6;
   localparam logic [3:0] OP_JRP  = 4'd7;
   localparam logic [3:0] OP_RFCT = 4'd8;
   localparam logic [3:0] OP_RPCT = 4'd9;
   localparam logic [3:0] OP_CRTN = 4'd10;
   localparam logic [3:0] OP_CJPP = 4'd11;
   localparam logic [3:0] OP_LDCT = 4'd12;
   localparam logic [3:0] OP_LOOP = 4'd13;
   localparam logic [3:0] OP_CONT = 4'd14;
   localparam logic [3:0] OP_TWB  = 4'd15;

   // A disabled condition (CCEN_N=1) always passes; otherwise the active-low
   // condition code must be asserted.
   function automatic logic cond_pass(input logic ccen_n, input logic cc_n);
      return ccen_n | ~cc_n;
   endfunction

endpackage

// File: rtl/microprogram_sequencer_if.sv
// -----------------------------------------------------------------------------
// microprogram_sequencer_if
// Bundles the pipeline-register side inputs and the status/strobe outputs of
// the sequencer. The tri-statable Y address bus stays a plain port on the
// sequencer itself.
//   master : pipeline register / controller side (drives I, D, conditions)
//   slave  : sequencer side (drives flags and source-select strobes)
// -----------------------------------------------------------------------------
interface microprogram_sequencer_if #(
   parameter int AW = 12
);
   logic [3:0]    I;
   logic [AW-1:0] D;
   logic          CC_N;
   logic          CCEN_N;
   logic          RLD_N;
   logic          CI;
   logic          OE_N;
   logic          FULL_N;
   logic          EMPTY_N;
   logic          PL_N;
   logic          MAP_N;
   logic          VECT_N;

   modport master (
      output I, D, CC_N, CCEN_N, RLD_N, CI, OE_N,
      input  FULL_N, EMPTY_N, PL_N, MAP_N, VECT_N
   );

   modport slave (
      input  I, D, CC_N, CCEN_N, RLD_N, CI, OE_N,
      output FULL_N, EMPTY_N, PL_N, MAP_N, VECT_N
   );
endinterface

// File: rtl/microprogram_sequencer_stack.sv
// -----------------------------------------------------------------------------
// seq_stack
// DEPTH x AW LIFO for subroutine return / loop addresses.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears SP only)
//   i_push, i_pop  : push i_din / pop top entry (never both in one cycle)
//   i_clear        : empty the stack, takes priority over push/pop
//   o_tos          : top-of-stack; entry 0 when empty (stale contents)
//   o_full_n       : registered, low when DEPTH entries are held
//   o_empty_n      : registered, low when no entries are held
// Push on a full stack overwrites the top entry; pop on empty is a no-op.
// -----------------------------------------------------------------------------
module seq_stack
   import am2900_pkg::*;
#(
   parameter int AW    = 12,
   parameter int DEPTH = 5,
   parameter int SPW   = 3
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_clear,
   input  logic [AW-1:0] i_din,
   output logic [AW-1:0] o_tos,
   output logic          o_full_n,
   output logic          o_empty_n
);

   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic [AW-1:0]  r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic [SPW-1:0] w_sp_nxt;
   logic [SPW-1:0] w_wr_idx;
   logic [SPW-1:0] w_rd_idx;
   logic           r_full_n;
   logic           r_empty_n;

   always_comb begin
      w_sp_nxt = r_sp;
      if (i_clear)
         w_sp_nxt = '0;
      else if (i_push && (r_sp != SP_FULL))
         w_sp_nxt = r_sp + 1'b1;
      else if (i_pop && (r_sp != '0))
         w_sp_nxt = r_sp - 1'b1;
   end

   // A push on a full stack lands on the existing top slot instead of
   // growing past the array.
   always_comb begin
      w_wr_idx = (r_sp == SP_FULL) ? (SP_FULL - 1'b1) : r_sp;
      w_rd_idx = (r_sp == '0) ? '0 : (r_sp - 1'b1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sp      <= '0;
         r_full_n  <= 1'b1;
         r_empty_n <= 1'b0;
      end else begin
         r_sp      <= w_sp_nxt;
         r_full_n  <= (w_sp_nxt != SP_FULL);
         r_empty_n <= (w_sp_nxt != '0);
      end
   end

   // Stack contents carry no reset: they are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_clear)
         r_mem[w_wr_idx] <= i_din;
   end

   assign o_tos     = r_mem[w_rd_idx];
   assign o_full_n  = r_full_n;
   assign o_empty_n = r_empty_n;

endmodule

// File: rtl/microprogram_sequencer.sv
// -----------------------------------------------------------------------------
// microprogram_sequencer
// Next-address generator between the pipeline register and the control store.
//   CP     : clock, rising edge
//   CLR_N  : asynchronous active-low reset (uPC=0, RC=0, stack empty)
//   bus    : slave side of microprogram_sequencer_if
//              in : I (opcode), D (branch addr / count), CC_N, CCEN_N,
//                   RLD_N (forced counter load), CI (incrementer carry), OE_N
//              out: FULL_N, EMPTY_N, PL_N, MAP_N, VECT_N
//   Y      : next microaddress, high impedance while OE_N=1
// The address, strobes and stack actions are decoded combinationally from I,
// the condition inputs and the current uPC/RC/stack state; all state updates
// on the rising edge of CP.
// -----------------------------------------------------------------------------
module microprogram_sequencer
   import am2900_pkg::*;
#(
   parameter int AW    = 12,
   parameter int DEPTH = 5,
   parameter int SPW   = 3
) (
   input  logic                      CP,
   input  logic                      CLR_N,
   microprogram_sequencer_if.slave   bus,
   output wire  [AW-1:0]             Y
);

   logic [AW-1:0] r_upc;
   logic [AW-1:0] r_rc;
   logic [AW-1:0] w_y;
   logic [AW-1:0] w_tos;
   logic          w_pass;
   logic          w_rcz;
   logic          w_push;
   logic          w_pop;
   logic          w_clear;
   logic          w_rc_ld;
   logic          w_rc_dec;

   assign w_pass = cond_pass(bus.CCEN_N, bus.CC_N);
   assign w_rcz  = (r_rc == '0);

   // Address select and side effects for each opcode. Decrement requests are
   // only raised when RC is non-zero, so RC saturates at zero.
   always_comb begin
      w_y      = r_upc;
      w_push   = 1'b0;
      w_pop    = 1'b0;
      w_clear  = 1'b0;
      w_rc_ld  = 1'b0;
      w_rc_dec = 1'b0;
      case (bus.I)
         OP_JZ: begin
            w_y     = '0;
            w_clear = 1'b1;
         end
         OP_CJS: begin
            if (w_pass) begin
               w_y    = bus.D;
               w_push = 1'b1;
            end
         end
         OP_JMAP: w_y = bus.D;
         OP_CJP:  if (w_pass) w_y = bus.D;
         OP_PUSH: begin
            w_push  = 1'b1;
            w_rc_ld = w_pass;
         end
         OP_JSRP: begin
            w_y    = w_pass ? bus.D : r_rc;
            w_push = 1'b1;
         end
         OP_CJV: if (w_pass) w_y = bus.D;
         OP_JRP: w_y = w_pass ? bus.D : r_rc;
         OP_RFCT: begin
            if (!w_rcz) begin
               w_y      = w_tos;
               w_rc_dec = 1'b1;
            end else begin
               w_pop = 1'b1;
            end
         end
         OP_RPCT: begin
            if (!w_rcz) begin
               w_y      = bus.D;
               w_rc_dec = 1'b1;
            end
         end
         OP_CRTN: begin
            if (w_pass) begin
               w_y   = w_tos;
               w_pop = 1'b1;
            end
         end
         OP_CJPP: begin
            if (w_pass) begin
               w_y   = bus.D;
               w_pop = 1'b1;
            end
         end
         OP_LDCT: w_rc_ld = 1'b1;
         OP_LOOP: begin
            if (w_pass)
               w_pop = 1'b1;
            else
               w_y = w_tos;
         end
         OP_CONT: ;
         OP_TWB: begin
            if (w_pass) begin
               w_pop = 1'b1;
            end else if (!w_rcz) begin
               w_y      = w_tos;
               w_rc_dec = 1'b1;
            end else begin
               w_y   = bus.D;
               w_pop = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Source-select strobes: map ROM for JMAP, vector for CJV, pipeline
   // register for everything else.
   always_comb begin
      bus.MAP_N  = (bus.I != OP_JMAP);
      bus.VECT_N = (bus.I != OP_CJV);
      bus.PL_N   = (bus.I == OP_JMAP) || (bus.I == OP_CJV);
   end

   // RLD_N overrides both an instruction load and a decrement.
   always_ff @(posedge CP or negedge CLR_N) begin
      if (!CLR_N) begin
         r_upc <= '0;
         r_rc  <= '0;
      end else begin
         r_upc <= w_y + AW'(bus.CI);
         if (!bus.RLD_N || w_rc_ld)
            r_rc <= bus.D;
         else if (w_rc_dec)
            r_rc <= r_rc - 1'b1;
      end
   end

   seq_stack #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .SPW   (SPW)
   ) u_stack (
      .i_clk     (CP),
      .i_rst_n   (CLR_N),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_clear   (w_clear),
      .i_din     (r_upc),
      .o_tos     (w_tos),
      .o_full_n  (bus.FULL_N),
      .o_empty_n (bus.EMPTY_N)
   );

   // Output enable gates only the pin; uPC keeps loading from w_y.
   assign Y = bus.OE_N ? {AW{1'bz}} : w_y;

endmodule
